fp_operand_stage: RTL and testbench

FP_OPERAND_STAGE -- requirements
Module: fp_operand_stage

---
 rtl/fp_operand_stage_if.sv | 51 +++++
 rtl/fp_operand_stage.sv | 109 ++++++++++
 tb/tb_fp_operand_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_stage_if
// Description : Bundle between the ID stage operand logic and its neighbours.
//               It carries decoded fields, the FPU pipeline destination and
//               write-enable taps, E3 and writeback data, and the operand and
//               control outputs toward the FPU.
//               master : the decode/FPU side that drives the stage.
//               slave  : fp_operand_stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_operand_stage_if;
  logic        ein;
  logic [4:0]  d_fs;
  logic [4:0]  d_ft;
  logic [4:0]  d_fd;
  logic [2:0]  d_fc;
  logic        d_wf;
  logic        d_ufs;
  logic        d_uft;
  logic        flush;
  logic [4:0]  e1n;
  logic [4:0]  e2n;
  logic [4:0]  e3n;
  logic        e1w;
  logic        e2w;
  logic        e3w;
  logic [31:0] ed;
  logic [4:0]  wn;
  logic [31:0] wd;
  logic        ww;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  fc;
  logic [4:0]  fd;
  logic        wf;
  logic        stall_raw;

  modport master (
    output ein, d_fs, d_ft, d_fd, d_fc, d_wf, d_ufs, d_uft, flush,
    output e1n, e2n, e3n, e1w, e2w, e3w, ed, wn, wd, ww,
    input  a, b, fc, fd, wf, stall_raw
  );

  modport slave (
    input  ein, d_fs, d_ft, d_fd, d_fc, d_wf, d_ufs, d_uft, flush,
    input  e1n, e2n, e3n, e1w, e2w, e3w, ed, wn, wd, ww,
    output a, b, fc, fd, wf, stall_raw
  );
endinterface
`default_nettype wire

// File: rtl/fp_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : fp_operand_stage
// Description : FP operand stage. It holds the 32x32 FP register file and the
//               ID pipeline register. It forwards E3 and writeback results
//               into the operands and interlocks on E1/E2 producers.
// Ports       : clk  - rising-edge clock
//               clrn - asynchronous active-low reset
//               bus  - fp_operand_stage_if.slave. It carries the decode
//                      inputs, the FPU stage taps, the writeback port and the
//                      operand/control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_stage (
  input  logic                clk,
  input  logic                clrn,
  fp_operand_stage_if.slave   bus
);

  logic [31:0] r_rf [32];

  logic [4:0]  r_fs;
  logic [4:0]  r_ft;
  logic [4:0]  r_fd;
  logic [2:0]  r_fc;
  logic        r_wf;
  logic        r_ufs;
  logic        r_uft;

  logic        w_haz_fs;
  logic        w_haz_ft;
  logic        w_stall;
  logic [31:0] w_a;
  logic [31:0] w_b;

  // Register file. Writeback is independent of ein, because a retiring FPU
  // result must land even while the front end is frozen.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'h0;
      end
    end else if (bus.ww) begin
      r_rf[bus.wn] <= bus.wd;
    end
  end

  // ID register. Flush wins over both load and hold, but only on an enabled
  // edge. A RAW stall freezes the held instruction.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_fs  <= 5'd0;
      r_ft  <= 5'd0;
      r_fd  <= 5'd0;
      r_fc  <= 3'd0;
      r_wf  <= 1'b0;
      r_ufs <= 1'b0;
      r_uft <= 1'b0;
    end else if (bus.ein) begin
      if (bus.flush) begin
        r_fd  <= 5'd0;
        r_fc  <= 3'd0;
        r_wf  <= 1'b0;
        r_ufs <= 1'b0;
        r_uft <= 1'b0;
      end else if (!w_stall) begin
        r_fs  <= bus.d_fs;
        r_ft  <= bus.d_ft;
        r_fd  <= bus.d_fd;
        r_fc  <= bus.d_fc;
        r_wf  <= bus.d_wf;
        r_ufs <= bus.d_ufs;
        r_uft <= bus.d_uft;
      end
    end
  end

  // E1/E2 producers cannot be forwarded yet, so any used source that matches
  // them interlocks. Register 0 is not special-cased.
  always_comb begin
    w_haz_fs = r_ufs & ((bus.e1w & (bus.e1n == r_fs)) |
                        (bus.e2w & (bus.e2n == r_fs)));
    w_haz_ft = r_uft & ((bus.e1w & (bus.e1n == r_ft)) |
                        (bus.e2w & (bus.e2n == r_ft)));
    w_stall  = w_haz_fs | w_haz_ft;
  end

  // Operand forwarding: E3 is younger than W, so E3 takes priority.
  always_comb begin
    if (bus.e3w && (bus.e3n == r_fs))      w_a = bus.ed;
    else if (bus.ww && (bus.wn == r_fs))   w_a = bus.wd;
    else                                   w_a = r_rf[r_fs];

    if (bus.e3w && (bus.e3n == r_ft))      w_b = bus.ed;
    else if (bus.ww && (bus.wn == r_ft))   w_b = bus.wd;
    else                                   w_b = r_rf[r_ft];
  end

  // Operands are gated by reset. Without the gate, forwarding inputs could
  // leak onto a/b while clrn is low.
  assign bus.a         = clrn ? w_a : 32'h0;
  assign bus.b         = clrn ? w_b : 32'h0;
  assign bus.fc        = r_fc;
  assign bus.fd        = r_fd;
  assign bus.wf        = r_wf & ~w_stall;
  assign bus.stall_raw = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_operand_stage
// Description : Directed self-checking bench for fp_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_operand_stage;

  logic clk;
  logic clrn;
  int   checks;
  int   failures;

  fp_operand_stage_if bus ();

  fp_operand_stage dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_fwd();
    bus.e1w = 1'b0; bus.e2w = 1'b0; bus.e3w = 1'b0; bus.ww = 1'b0;
    bus.e1n = 5'd0; bus.e2n = 5'd0; bus.e3n = 5'd0; bus.wn = 5'd0;
    bus.ed  = 32'h0; bus.wd = 32'h0; bus.flush = 1'b0;
  endtask

  task automatic load_id(input logic [4:0] fs, input logic [4:0] ft, input logic [4:0] fd,
                         input logic [2:0] fc, input logic wf, input logic ufs, input logic uft);
    @(negedge clk);
    bus.d_fs = fs; bus.d_ft = ft; bus.d_fd = fd; bus.d_fc = fc;
    bus.d_wf = wf; bus.d_ufs = ufs; bus.d_uft = uft;
    bus.ein = 1'b1; bus.flush = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    bus.ein = 1'b1;
    bus.d_fs = 5'd5; bus.d_ft = 5'd5; bus.d_fd = 5'd0; bus.d_fc = 3'd0;
    bus.d_wf = 1'b0; bus.d_ufs = 1'b0; bus.d_uft = 1'b0;
    clear_fwd();
    // A forwarding match on register 0 while in reset must not reach a.
    bus.e3w = 1'b1; bus.e3n = 5'd0; bus.ed = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.a !== 32'h0) begin failures++; $display("FAIL reset_a got=%h exp=%h", bus.a, 32'h0); end
    checks++; if (bus.wf !== 1'b0) begin failures++; $display("FAIL reset_wf got=%b exp=0", bus.wf); end
    checks++; if (bus.stall_raw !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_raw); end
    @(negedge clk);
    clear_fwd();
    clrn = 1'b1;
    // Read f5 after reset.
    load_id(5'd5, 5'd5, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.a !== 32'h0) begin failures++; $display("FAIL reset_f5 got=%h exp=%h", bus.a, 32'h0); end
  endtask

  task automatic test_regfile_write();
    @(negedge clk);
    bus.ww = 1'b1; bus.wn = 5'd3; bus.wd = 32'h3F800000;
    @(posedge clk);
    @(negedge clk);
    clear_fwd();
    load_id(5'd3, 5'd0, 5'd2, 3'd1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.a !== 32'h3F800000) begin failures++; $display("FAIL rf_write_a got=%h exp=%h", bus.a, 32'h3F800000); end
    checks++; if (bus.wf !== 1'b1) begin failures++; $display("FAIL rf_write_wf got=%b exp=1", bus.wf); end
    checks++; if (bus.fd !== 5'd2 || bus.fc !== 3'd1) begin failures++; $display("FAIL rf_write_ctl got=%0d/%0d exp=2/1", bus.fd, bus.fc); end
  endtask

  task automatic test_fwd_priority();
    load_id(5'd7, 5'd0, 5'd1, 3'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus.e3w = 1'b1; bus.e3n = 5'd7; bus.ed = 32'h40000000;
    bus.ww  = 1'b1; bus.wn  = 5'd7; bus.wd = 32'h3F800000;
    #1;
    checks++; if (bus.a !== 32'h40000000) begin failures++; $display("FAIL e3_wins got=%h exp=%h", bus.a, 32'h40000000); end
    checks++; if (bus.stall_raw !== 1'b0) begin failures++; $display("FAIL e3_nostall got=%b exp=0", bus.stall_raw); end
    bus.e3w = 1'b0;
    #1;
    checks++; if (bus.a !== 32'h3F800000) begin failures++; $display("FAIL w_fwd got=%h exp=%h", bus.a, 32'h3F800000); end
    @(posedge clk);
    @(negedge clk);
    clear_fwd();
    #1;
    checks++; if (bus.a !== 32'h3F800000) begin failures++; $display("FAIL w_landed got=%h exp=%h", bus.a, 32'h3F800000); end
  endtask

  task automatic test_e1_stall();
    load_id(5'd1, 5'd9, 5'd4, 3'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.e1w = 1'b1; bus.e1n = 5'd9;
    bus.d_fd = 5'd31; bus.d_ft = 5'd0; bus.d_uft = 1'b0;
    #1;
    checks++; if (bus.stall_raw !== 1'b1 || bus.wf !== 1'b0) begin failures++; $display("FAIL stall_c1 got=%b/%b exp=1/0", bus.stall_raw, bus.wf); end
    @(posedge clk);
    @(negedge clk);
    bus.e1w = 1'b0; bus.e2w = 1'b1; bus.e2n = 5'd9;
    #1;
    checks++; if (bus.stall_raw !== 1'b1 || bus.wf !== 1'b0 || bus.fd !== 5'd4) begin failures++; $display("FAIL stall_c2 got=%b/%b/%0d exp=1/0/4", bus.stall_raw, bus.wf, bus.fd); end
    @(posedge clk);
    @(negedge clk);
    bus.e2w = 1'b0; bus.e3w = 1'b1; bus.e3n = 5'd9; bus.ed = 32'h12345678;
    #1;
    checks++; if (bus.stall_raw !== 1'b0 || bus.b !== 32'h12345678) begin failures++; $display("FAIL stall_release got=%b/%h exp=0/12345678", bus.stall_raw, bus.b); end
    checks++; if (bus.wf !== 1'b1 || bus.fd !== 5'd4) begin failures++; $display("FAIL stall_held got=%b/%0d exp=1/4", bus.wf, bus.fd); end
    @(posedge clk); #1;
    checks++; if (bus.fd !== 5'd31) begin failures++; $display("FAIL stall_next_load got=%0d exp=31", bus.fd); end
    @(negedge clk);
    clear_fwd();
  endtask

  task automatic test_no_use_and_flush();
    load_id(5'd1, 5'd9, 5'd4, 3'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.e1w = 1'b1; bus.e1n = 5'd9;
    #1;
    checks++; if (bus.stall_raw !== 1'b0 || bus.wf !== 1'b1) begin failures++; $display("FAIL no_use got=%b/%b exp=0/1", bus.stall_raw, bus.wf); end
    bus.e1w = 1'b0;
    load_id(5'd1, 5'd9, 5'd5, 3'd3, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.e1w = 1'b1; bus.e1n = 5'd9;
    #1;
    checks++; if (bus.stall_raw !== 1'b1) begin failures++; $display("FAIL flush_pre got=%b exp=1", bus.stall_raw); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.wf !== 1'b0 || bus.stall_raw !== 1'b0) begin failures++; $display("FAIL flush got=%b/%b exp=0/0", bus.wf, bus.stall_raw); end
    checks++; if (bus.fd !== 5'd0 || bus.fc !== 3'd0) begin failures++; $display("FAIL flush_ctl got=%0d/%0d exp=0/0", bus.fd, bus.fc); end
    @(negedge clk);
    clear_fwd();
  endtask

  task automatic test_ein_hold();
    load_id(5'd2, 5'd3, 5'd6, 3'd1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    bus.ein = 1'b0;
    bus.d_fs = 5'd10; bus.d_ft = 5'd11; bus.d_fd = 5'd12;
    bus.ww = 1'b1; bus.wn = 5'd2; bus.wd = 32'hAAAA5555;
    bus.e3w = 1'b1; bus.e3n = 5'd3; bus.ed = 32'hBEEF0000;
    #1;
    checks++; if (bus.b !== 32'hBEEF0000 || bus.a !== 32'hAAAA5555) begin failures++; $display("FAIL ein0_fwd got=%h/%h exp=aaaa5555/beef0000", bus.a, bus.b); end
    @(posedge clk);
    @(negedge clk);
    clear_fwd();
    bus.e1w = 1'b1; bus.e1n = 5'd2;
    #1;
    checks++; if (bus.stall_raw !== 1'b1 || bus.fd !== 5'd6) begin failures++; $display("FAIL ein0_stall got=%b/%0d exp=1/6", bus.stall_raw, bus.fd); end
    @(posedge clk);
    @(negedge clk);
    bus.e1w = 1'b0;
    #1;
    checks++; if (bus.a !== 32'hAAAA5555 || bus.fd !== 5'd6 || bus.stall_raw !== 1'b0) begin failures++; $display("FAIL ein0_hold got=%h/%0d/%b exp=aaaa5555/6/0", bus.a, bus.fd, bus.stall_raw); end
    @(posedge clk);
    @(negedge clk);
    bus.ein = 1'b1;
  endtask

  task automatic test_reg0_and_same_src();
    @(negedge clk);
    bus.ww = 1'b1; bus.wn = 5'd0; bus.wd = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    clear_fwd();
    load_id(5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.a !== 32'h11111111 || bus.b !== 32'h11111111) begin failures++; $display("FAIL reg0_rd got=%h/%h exp=11111111", bus.a, bus.b); end
    @(negedge clk);
    bus.e3w = 1'b1; bus.e3n = 5'd0; bus.ed = 32'h22222222;
    #1;
    checks++; if (bus.a !== 32'h22222222 || bus.b !== 32'h22222222) begin failures++; $display("FAIL same_src got=%h/%h exp=22222222", bus.a, bus.b); end
    bus.e3w = 1'b0; bus.e2w = 1'b1; bus.e2n = 5'd0;
    #1;
    checks++; if (bus.stall_raw !== 1'b1) begin failures++; $display("FAIL reg0_stall got=%b exp=1", bus.stall_raw); end
    clear_fwd();
  endtask

  task automatic test_reset_mid_stall();
    load_id(5'd1, 5'd9, 5'd8, 3'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.e1w = 1'b1; bus.e1n = 5'd9;
    #1;
    clrn = 1'b0;
    #1;
    checks++; if (bus.fd !== 5'd0 || bus.fc !== 3'd0 || bus.stall_raw !== 1'b0) begin failures++; $display("FAIL mid_rst got=%0d/%0d/%b exp=0/0/0", bus.fd, bus.fc, bus.stall_raw); end
    @(negedge clk);
    clrn = 1'b1;
    bus.e1w = 1'b0;
    bus.d_fd = 5'd21; bus.d_wf = 1'b1; bus.d_fc = 3'd6;
    @(posedge clk); #1;
    checks++; if (bus.fd !== 5'd21 || bus.wf !== 1'b1 || bus.fc !== 3'd6) begin failures++; $display("FAIL post_rst_load got=%0d/%b/%0d exp=21/1/6", bus.fd, bus.wf, bus.fc); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_regfile_write();
    test_fwd_priority();
    test_e1_stall();
    test_no_use_and_flush();
    test_ein_hold();
    test_reg0_and_same_src();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
